coin_acceptor: RTL
==================

Name: coin_acceptor

Overview:
Front-end stage directly upstream of the vending Moore FSM. It synchronizes and debounces two raw coin-sensor lines (coin A, coin B) and classifies each insertion as A, B or simultaneous AB. Classified coins are queued in a small FIFO and presented to the vending FSM over a valid/ready handshake. Coins that cannot be accepted (acceptor disabled, or FIFO full) are flagged for mechanical return.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive synchronized-high samples that qualify a coin; also the consecutive low samples that qualify release; legal range 2..255
FIFO_DEPTH, 4, number of queued coin events; must be a power of 2, minimum 2

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
sensor_a  input  1  raw coin-A sensor, asynchronous to clk, high while coin present
sensor_b  input  1  raw coin-B sensor, asynchronous to clk
accept_en  input  1  1 = coins may be queued; 0 = every detected coin is rejected
coin_ready  input  1  downstream FSM consumes head entry when high with coin_valid
clr_ovf  input  1  synchronous clear of the overflow flag
coin_valid  output  1  FIFO non-empty
coin_code  output  2  head entry: 01 = A, 10 = B, 11 = AB; 00 when empty
reject  output  1  one-cycle pulse: a detected coin was dropped (return chute)
overflow  output  1  sticky: a coin was dropped because the FIFO was full
fill_level  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy
tally_a  output  8  accepted A coins (AB counts toward both); see Optional Feature
tally_b  output  8  accepted B coins; see Optional Feature

Behaviour:
- Reset (async): synchronizers, debounce FSMs and counters cleared; FIFO emptied; coin_valid=0, coin_code=00, reject=0, overflow=0, fill_level=0, tally_a=tally_b=0.
- Synchronizer: two-flop per sensor. sync_x is the second-flop output.
- Debounce FSM, one per channel, with states IDLE, RISE, HIGH, FALL and counter cnt:
  - IDLE: sync_x=1 -> RISE, cnt=1.
  - RISE: sync_x=0 -> IDLE. Otherwise, if cnt==DEBOUNCE_CYCLES-1 -> HIGH and assert det_x for exactly 1 cycle; else cnt++.
  - HIGH: sync_x=0 -> FALL, cnt=1.
  - FALL: sync_x=1 -> HIGH, with no new detection. Otherwise, if cnt==DEBOUNCE_CYCLES-1 -> IDLE; else cnt++.
  - A pulse that gives fewer than DEBOUNCE_CYCLES consecutive high samples produces no event.
  - Exactly one event per qualified insertion. Bounce during release never re-triggers.
- Classification:
  - det_a and det_b in the same cycle -> one event, code 11.
  - Otherwise, det_a -> 01 and det_b -> 10.
  - Detections in different cycles are always separate events.
- Enqueue, evaluated in the cycle after det:
  - accept_en=0: event dropped, reject=1 for 1 cycle, overflow unchanged.
  - accept_en=1 and FIFO full with no pop this cycle: event dropped, reject=1, overflow set.
  - Otherwise the event is written.
  - Full with a simultaneous pop: the push is accepted and occupancy is unchanged.
- Latency: the first rising clk edge that samples the sensor high is edge 0. With the FIFO empty and accept_en=1, coin_valid is high after edge DEBOUNCE_CYCLES+2 (edge 6 with the default), assuming the sensor stays high.
- Dequeue:
  - coin_valid && coin_ready pops the head on that edge; coin_code then shows the next entry, or 00 if the FIFO empties.
  - coin_ready while empty has no effect.
  - coin_code is registered and stable while coin_valid=1 and coin_ready=0.
- fill_level tracks occupancy every cycle: +1 on push only, -1 on pop only, unchanged on both or neither.
- overflow: set by a full-drop, cleared by clr_ovf. If set and clear occur in the same cycle, set wins.
- Pointer wrap: read and write pointers wrap modulo FIFO_DEPTH. Full/empty are distinguished by the extra pointer bit, not by comparing pointers alone.
- rst mid-debounce or mid-transfer: all queued coins are discarded and no reject pulse is generated. A sensor still held high after reset release is treated as a new insertion.

Optional Feature:
Macro COIN_TALLY_EN.
- Defined: tally_a/tally_b are 8-bit counters that increment on each accepted (written) event. Code 01 increments tally_a, code 10 increments tally_b, and code 11 increments both. Counters saturate at 255 and are cleared only by rst.
- Not defined: tally_a/tally_b are tied to 0 and no counter logic is synthesized.

Test Plan:
1. rst pulse mid-cycle, then sensor_a high for 10 cycles, coin_ready=1, accept_en=1 -> coin_valid high for 1 cycle after edge 6, code 01; fill_level returns to 0; exactly one event.
2. sensor_b glitch high for 3 cycles (DEBOUNCE_CYCLES=4), then low -> no event, reject=0, fill_level=0. Sensor_b high for 8 cycles with 2 bounce cycles at release -> exactly one event, code 10.
3. sensor_a and sensor_b rising on the same edge, held 8 cycles -> one entry, code 11. With COIN_TALLY_EN: tally_a=1, tally_b=1.
4. coin_ready=0, five A insertions -> after fourth, fill_level=4; fifth gives reject pulse and overflow=1. clr_ovf pulse -> overflow=0. Then ready=1 drains four 01 entries in order.
5. FIFO full, fifth coin's enqueue cycle coincides with coin_ready=1 -> no reject, overflow stays 0, fill_level stays 4.
6. accept_en=0, one B insertion -> reject pulse, fill_level=0, overflow=0, tally_b unchanged. Assert rst with 2 entries queued -> coin_valid=0, fill_level=0 immediately.

Source files
------------

// File: rtl/coin_acceptor.sv
// Coin acceptor front end: per-channel sync + debounce, A/B/AB classification, coin FIFO.
// Define COIN_TALLY_EN to build the saturating accepted-coin tally counters.
module coin_acceptor #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int FIFO_DEPTH      = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          sensor_a,
   input  logic                          sensor_b,
   input  logic                          accept_en,
   input  logic                          coin_ready,
   input  logic                          clr_ovf,
   output logic                          coin_valid,
   output logic [1:0]                    coin_code,
   output logic                          reject,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fill_level,
   output logic [7:0]                    tally_a,
   output logic [7:0]                    tally_b
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, RISE, HIGH, FALL} deb_state_t;

   logic [1:0] sensor_raw;
   logic [1:0] det;

   assign sensor_raw = {sensor_b, sensor_a};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_chan
         deb_state_t state_reg, state_next;
         logic [7:0] cnt_reg, cnt_next;
         logic       meta_reg, sync_reg, det_reg, det_next;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               meta_reg  <= 1'b0;
               sync_reg  <= 1'b0;
               state_reg <= IDLE;
               cnt_reg   <= 8'd0;
               det_reg   <= 1'b0;
            end else begin
               meta_reg  <= sensor_raw[gi];
               sync_reg  <= meta_reg;
               state_reg <= state_next;
               cnt_reg   <= cnt_next;
               det_reg   <= det_next;
            end
         end

         always_comb begin
            state_next = state_reg;
            cnt_next   = cnt_reg;
            det_next   = 1'b0;
            case (state_reg)
               IDLE: if (sync_reg) begin
                  state_next = RISE;
                  cnt_next   = 8'd1;
               end
               RISE: if (!sync_reg) begin
                  state_next = IDLE;
               end else if (cnt_reg == CNT_LAST) begin
                  state_next = HIGH;
                  det_next   = 1'b1;
               end else begin
                  cnt_next = cnt_reg + 8'd1;
               end
               HIGH: if (!sync_reg) begin
                  state_next = FALL;
                  cnt_next   = 8'd1;
               end
               // Returning to HIGH on a release bounce never raises a new detection.
               FALL: if (sync_reg) begin
                  state_next = HIGH;
               end else if (cnt_reg == CNT_LAST) begin
                  state_next = IDLE;
               end else begin
                  cnt_next = cnt_reg + 8'd1;
               end
               default: state_next = IDLE;
            endcase
         end

         assign det[gi] = det_reg;
      end
   endgenerate

   logic [AW:0] wr_ptr_reg, rd_ptr_reg;
   logic [1:0]  mem [FIFO_DEPTH];
   logic        reject_reg, overflow_reg;
   logic        event_det, full, pop, push, drop, ovf_set;

   assign event_det = |det;
   assign full      = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
   assign coin_valid = (wr_ptr_reg != rd_ptr_reg);
   assign pop       = coin_valid && coin_ready;
   // A pop on the same edge frees the slot, so a full FIFO can still take the push.
   assign push      = event_det && accept_en && (!full || pop);
   assign drop      = event_det && !push;
   assign ovf_set   = event_det && accept_en && full && !pop;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         reject_reg   <= 1'b0;
         overflow_reg <= 1'b0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         reject_reg <= drop;
         if (ovf_set)
            overflow_reg <= 1'b1;
         else if (clr_ovf)
            overflow_reg <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_reg[AW-1:0]] <= det;
   end

   assign coin_code  = coin_valid ? mem[rd_ptr_reg[AW-1:0]] : 2'b00;
   assign fill_level = wr_ptr_reg - rd_ptr_reg;
   assign reject     = reject_reg;
   assign overflow   = overflow_reg;

`ifdef COIN_TALLY_EN
   logic [7:0] tally_a_reg, tally_b_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tally_a_reg <= 8'd0;
         tally_b_reg <= 8'd0;
      end else begin
         if (push && det[0] && (tally_a_reg != 8'hFF)) tally_a_reg <= tally_a_reg + 8'd1;
         if (push && det[1] && (tally_b_reg != 8'hFF)) tally_b_reg <= tally_b_reg + 8'd1;
      end
   end

   assign tally_a = tally_a_reg;
   assign tally_b = tally_b_reg;
`else
   assign tally_a = 8'd0;
   assign tally_b = 8'd0;
`endif
endmodule
